// File: rtl/dll_rx_dllp_decoder.sv
// Receive-side DLLP decoder: per-slot CRC-16 check, FC/AckNak decode for one VC,
// same-cycle merge, sticky InitFC flags and saturating error counters.
module dll_rx_dllp_decoder #(
  parameter int         NUM_DLLP = 2,
  parameter logic [2:0] VC_ID    = 3'd0,
  parameter int         CNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [48*NUM_DLLP-1:0] dllp_i,
  input  logic [NUM_DLLP-1:0]   dllp_valid_i,
  input  logic                  clr_i,
  output logic [2:0]            fc_valid_o,
  output logic [5:0]            fc_phase_o,
  output logic [17:0]           fc_hdr_o,
  output logic [35:0]           fc_data_o,
  output logic                  acknak_valid_o,
  output logic                  acknak_is_nak_o,
  output logic [11:0]           acknak_seq_o,
  output logic [2:0]            initfc1_seen_o,
  output logic [2:0]            initfc2_seen_o,
  output logic [CNT_W-1:0]      crc_err_cnt_o,
  output logic [CNT_W-1:0]      unsup_cnt_o
);

  logic [48*NUM_DLLP-1:0] s1_dllp;
  logic [NUM_DLLP-1:0]    s1_valid;

  logic [2:0]  fc_valid_n;
  logic [5:0]  phase_n;
  logic [17:0] hdr_n;
  logic [35:0] data_n;
  logic        ak_valid_n;
  logic        nak_n;
  logic [11:0] seq_n;
  logic [2:0]  seen1_set;
  logic [2:0]  seen2_set;
  logic [2:0]  crc_inc;
  logic [2:0]  unsup_inc;
  logic [47:0] slot;
  logic [7:0]  tbyte;
  logic [1:0]  ph;
  logic [1:0]  ft;
  logic        is_fc;
  logic [NUM_DLLP*6-1:0] unused_rsv;

  function automatic logic [15:0] crc16(input logic [31:0] b);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 31; i >= 0; i--)
      c = {c[14:0], 1'b0} ^ ((c[15] ^ b[i]) ? 16'h1021 : 16'h0000);
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [2:0] inc);
    logic [CNT_W+2:0] s;
    s = {3'b000, c} + {{CNT_W{1'b0}}, inc};
    if (s > {3'b000, {CNT_W{1'b1}}}) return {CNT_W{1'b1}};
    return s[CNT_W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_dllp  <= '0;
      s1_valid <= '0;
    end else begin
      s1_dllp  <= dllp_i;
      s1_valid <= dllp_valid_i;
    end
  end

  // Slots are walked in arrival order, so a later accepted slot overwrites earlier ones.
  always_comb begin
    fc_valid_n = '0;
    phase_n    = fc_phase_o;
    hdr_n      = fc_hdr_o;
    data_n     = fc_data_o;
    ak_valid_n = 1'b0;
    nak_n      = acknak_is_nak_o;
    seq_n      = acknak_seq_o;
    seen1_set  = '0;
    seen2_set  = '0;
    crc_inc    = '0;
    unsup_inc  = '0;
    slot       = '0;
    tbyte      = '0;
    ph         = '0;
    ft         = '0;
    is_fc      = 1'b0;
    unused_rsv = '0;
    for (int k = 0; k < NUM_DLLP; k++) begin
      slot  = s1_dllp[48*k +: 48];
      tbyte = slot[7:0];
      unused_rsv[6*k +: 6] = {slot[23:20], slot[15:14]};
      ft    = tbyte[5:4];
      is_fc = 1'b1;
      case (tbyte[7:4])
        4'h4, 4'h5, 4'h6: ph = 2'b01;
        4'hC, 4'hD, 4'hE: ph = 2'b10;
        4'h8, 4'h9, 4'hA: ph = 2'b00;
        default: begin
          ph    = 2'b00;
          is_fc = 1'b0;
        end
      endcase
      if (s1_valid[k]) begin
        if (slot[47:32] != crc16(slot[31:0])) begin
          crc_inc = crc_inc + 3'd1;
        end else if (is_fc && !tbyte[3]) begin
          if (tbyte[2:0] == VC_ID) begin
            fc_valid_n[ft]       = 1'b1;
            phase_n[2*ft +: 2]   = ph;
            hdr_n[6*ft +: 6]     = slot[13:8];
            data_n[12*ft +: 12]  = {slot[19:16], slot[31:24]};
            if (ph == 2'b01) seen1_set[ft] = 1'b1;
            if (ph == 2'b10) seen2_set[ft] = 1'b1;
          end
        end else if (tbyte == 8'h00 || tbyte == 8'h10) begin
          ak_valid_n = 1'b1;
          nak_n      = tbyte[4];
          seq_n      = {slot[19:16], slot[31:24]};
        end else begin
          unsup_inc = unsup_inc + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fc_valid_o      <= '0;
      fc_phase_o      <= '0;
      fc_hdr_o        <= '0;
      fc_data_o       <= '0;
      acknak_valid_o  <= 1'b0;
      acknak_is_nak_o <= 1'b0;
      acknak_seq_o    <= '0;
      initfc1_seen_o  <= '0;
      initfc2_seen_o  <= '0;
      crc_err_cnt_o   <= '0;
      unsup_cnt_o     <= '0;
    end else begin
      fc_valid_o      <= fc_valid_n;
      fc_phase_o      <= phase_n;
      fc_hdr_o        <= hdr_n;
      fc_data_o       <= data_n;
      acknak_valid_o  <= ak_valid_n;
      acknak_is_nak_o <= nak_n;
      acknak_seq_o    <= seq_n;
      if (clr_i) begin
        initfc1_seen_o <= '0;
        initfc2_seen_o <= '0;
        crc_err_cnt_o  <= '0;
        unsup_cnt_o    <= '0;
      end else begin
        initfc1_seen_o <= initfc1_seen_o | seen1_set;
        initfc2_seen_o <= initfc2_seen_o | seen2_set;
        crc_err_cnt_o  <= sat_add(crc_err_cnt_o, crc_inc);
        unsup_cnt_o    <= sat_add(unsup_cnt_o, unsup_inc);
      end
    end
  end

endmodule

// File: tb/tb_dll_rx_dllp_decoder.sv
// Bench for dll_rx_dllp_decoder: directed scenarios plus randomized groups
// checked against a queue-based reference model.
module tb_dll_rx_dllp_decoder;
  localparam int         N  = 2;
  localparam logic [2:0] VC = 3'd0;
  localparam int         CW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [48*N-1:0] dllp;
  logic [N-1:0]    dval;
  logic            clr;
  logic [2:0]      fc_valid;
  logic [5:0]      fc_phase;
  logic [17:0]     fc_hdr;
  logic [35:0]     fc_data;
  logic            ak_valid;
  logic            ak_nak;
  logic [11:0]     ak_seq;
  logic [2:0]      seen1;
  logic [2:0]      seen2;
  logic [CW-1:0]   crc_cnt;
  logic [CW-1:0]   uns_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  dll_rx_dllp_decoder #(.NUM_DLLP(N), .VC_ID(VC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .dllp_i(dllp), .dllp_valid_i(dval), .clr_i(clr),
    .fc_valid_o(fc_valid), .fc_phase_o(fc_phase), .fc_hdr_o(fc_hdr), .fc_data_o(fc_data),
    .acknak_valid_o(ak_valid), .acknak_is_nak_o(ak_nak), .acknak_seq_o(ak_seq),
    .initfc1_seen_o(seen1), .initfc2_seen_o(seen2),
    .crc_err_cnt_o(crc_cnt), .unsup_cnt_o(uns_cnt)
  );

  always #5 clk = ~clk;

  // CRC as polynomial division of (body * x^16 + 0xFFFF * x^32) by x^16+x^12+x^5+1.
  function automatic logic [15:0] ref_crc(input logic [31:0] body);
    logic [47:0] m;
    m = {body, 16'h0000} ^ {16'hFFFF, 32'h0};
    for (int i = 47; i >= 16; i--)
      if (m[i]) m[i -: 17] = m[i -: 17] ^ 17'h11021;
    return m[15:0];
  endfunction

  function automatic logic [47:0] mk_fc(input logic [7:0] t, input logic [5:0] hdr, input logic [11:0] data);
    logic [31:0] b;
    b = {data[7:0], 4'h0, data[11:8], 2'b00, hdr, t};
    return {ref_crc(b), b};
  endfunction

  function automatic logic [47:0] mk_ak(input logic nak, input logic [11:0] seq);
    logic [31:0] b;
    b = {seq[7:0], 4'h0, seq[11:8], 8'h00, (nak ? 8'h10 : 8'h00)};
    return {ref_crc(b), b};
  endfunction

  function automatic logic [47:0] corrupt(input logic [47:0] d);
    logic [47:0] m;
    m = 48'h1 << (32 + $urandom_range(0, 15));
    return d ^ m;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dllp = '0;
    dval = '0;
    clr  = 1'b0;
  endtask

  task automatic do_clear();
    idle();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [48*N-1:0] d;
    logic [N-1:0]    v;
  } grp_t;
  grp_t pipe_q[$];

  logic [2:0]  m_fcv;
  logic [1:0]  m_ph[3];
  logic [5:0]  m_hdr[3];
  logic [11:0] m_dat[3];
  logic        m_akv, m_nak;
  logic [11:0] m_seq;
  logic [2:0]  m_s1, m_s2;
  int          m_crc, m_uns;

  task automatic model_reset();
    grp_t g;
    g = '0;
    m_fcv = '0; m_akv = 1'b0; m_nak = 1'b0; m_seq = '0;
    m_s1 = '0; m_s2 = '0; m_crc = 0; m_uns = 0;
    for (int t = 0; t < 3; t++) begin m_ph[t] = '0; m_hdr[t] = '0; m_dat[t] = '0; end
    pipe_q.delete();
    pipe_q.push_back(g);
  endtask

  task automatic model_apply(input grp_t g, input logic c);
    int ci, ui, hi, ft, ph, maxc;
    logic [47:0] s;
    logic [7:0]  tb;
    ci = 0; ui = 0; m_fcv = '0; m_akv = 1'b0;
    maxc = (1 << CW) - 1;
    for (int k = 0; k < N; k++) begin
      if (!g.v[k]) continue;
      s = g.d[48*k +: 48];
      tb = s[7:0];
      if (s[47:32] != ref_crc(s[31:0])) begin ci++; continue; end
      hi = int'(tb) / 16;
      ft = -1; ph = 0;
      if (hi >= 4 && hi <= 6)        begin ph = 1; ft = hi - 4;  end
      else if (hi >= 12 && hi <= 14) begin ph = 2; ft = hi - 12; end
      else if (hi >= 8 && hi <= 10)  begin ph = 0; ft = hi - 8;  end
      if (ft >= 0 && (int'(tb) % 16) < 8) begin
        if ((int'(tb) % 8) == int'(VC)) begin
          m_fcv[ft] = 1'b1;
          m_ph[ft]  = 2'(ph);
          m_hdr[ft] = s[13:8];
          m_dat[ft] = {s[19:16], s[31:24]};
          if (ph == 1) m_s1[ft] = 1'b1;
          if (ph == 2) m_s2[ft] = 1'b1;
        end
      end else if (tb == 8'h00 || tb == 8'h10) begin
        m_akv = 1'b1;
        m_nak = (tb == 8'h10);
        m_seq = {s[19:16], s[31:24]};
      end else begin
        ui++;
      end
    end
    m_crc = (m_crc + ci > maxc) ? maxc : m_crc + ci;
    m_uns = (m_uns + ui > maxc) ? maxc : m_uns + ui;
    if (c) begin m_s1 = '0; m_s2 = '0; m_crc = 0; m_uns = 0; end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle();
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    n_checks++; if (fc_valid !== 3'b0) $display("FAIL reset_fc_valid: got %b want 000", fc_valid); else n_pass++;
    n_checks++; if ({fc_phase, fc_hdr, fc_data} !== '0) $display("FAIL reset_fc_fields: got %h want 0", {fc_phase, fc_hdr, fc_data}); else n_pass++;
    n_checks++; if ({ak_valid, ak_nak, ak_seq} !== '0) $display("FAIL reset_acknak: got %h want 0", {ak_valid, ak_nak, ak_seq}); else n_pass++;
    n_checks++; if ({seen1, seen2, crc_cnt, uns_cnt} !== '0) $display("FAIL reset_sticky: got %h want 0", {seen1, seen2, crc_cnt, uns_cnt}); else n_pass++;
  endtask

  task automatic test_single_updatefc();
    idle();
    dllp[47:0] = mk_fc(8'h90, 6'h15, 12'hA5C);
    dval = 2'b01;
    cyc();
    idle();
    n_checks++; if (fc_valid !== 3'b0) $display("FAIL single_early: got %b want 000", fc_valid); else n_pass++;
    cyc();
    n_checks++; if (fc_valid !== 3'b010) $display("FAIL single_valid: got %b want 010", fc_valid); else n_pass++;
    n_checks++; if (fc_hdr[11:6] !== 6'h15) $display("FAIL single_np_hdr: got %h want 15", fc_hdr[11:6]); else n_pass++;
    n_checks++; if (fc_data[23:12] !== 12'hA5C) $display("FAIL single_np_data: got %h want a5c", fc_data[23:12]); else n_pass++;
    n_checks++; if (fc_phase[3:2] !== 2'b00) $display("FAIL single_np_phase: got %b want 00", fc_phase[3:2]); else n_pass++;
    n_checks++; if ({fc_hdr[5:0], fc_hdr[17:12], fc_data[11:0], fc_data[35:24]} !== '0) $display("FAIL single_p_cpl_hold: got %h want 0", {fc_hdr[5:0], fc_hdr[17:12], fc_data[11:0], fc_data[35:24]}); else n_pass++;
    cyc();
    n_checks++; if (fc_valid !== 3'b0) $display("FAIL single_pulse_len: got %b want 000", fc_valid); else n_pass++;
    n_checks++; if (fc_hdr[11:6] !== 6'h15) $display("FAIL single_hold: got %h want 15", fc_hdr[11:6]); else n_pass++;
  endtask

  task automatic test_same_cycle_merge();
    idle();
    dllp = {mk_fc(8'h40, 6'h08, 12'h123), mk_fc(8'h40, 6'h20, 12'h456)};
    dval = 2'b11;
    cyc(); idle(); cyc();
    n_checks++; if (fc_valid !== 3'b001) $display("FAIL merge_valid: got %b want 001", fc_valid); else n_pass++;
    n_checks++; if (fc_hdr[5:0] !== 6'h08) $display("FAIL merge_p_hdr: got %h want 08", fc_hdr[5:0]); else n_pass++;
    n_checks++; if (fc_phase[1:0] !== 2'b01) $display("FAIL merge_p_phase: got %b want 01", fc_phase[1:0]); else n_pass++;
    n_checks++; if (seen1 !== 3'b001) $display("FAIL merge_seen1: got %b want 001", seen1); else n_pass++;
  endtask

  task automatic test_crc_nak_saturate();
    do_clear();
    dllp = {mk_ak(1'b1, 12'h7FF), corrupt(mk_fc(8'h80, 6'h01, 12'h001))};
    dval = 2'b11;
    cyc(); idle(); cyc();
    n_checks++; if (crc_cnt !== 8'd1) $display("FAIL nak_crc_cnt: got %0d want 1", crc_cnt); else n_pass++;
    n_checks++; if ({ak_valid, ak_nak, ak_seq} !== {1'b1, 1'b1, 12'h7FF}) $display("FAIL nak_fields: got %b %b %h want 1 1 7ff", ak_valid, ak_nak, ak_seq); else n_pass++;
    n_checks++; if (fc_valid !== 3'b0) $display("FAIL nak_no_fc: got %b want 000", fc_valid); else n_pass++;
    for (int i = 0; i < 150; i++) begin
      dllp = {corrupt(mk_ak(1'b0, 12'(i))), corrupt(mk_fc(8'h90, 6'(i), 12'(i)))};
      dval = 2'b11;
      cyc();
    end
    idle(); cyc(); cyc();
    n_checks++; if (crc_cnt !== 8'hFF) $display("FAIL crc_saturate: got %h want ff", crc_cnt); else n_pass++;
    n_checks++; if (ak_valid !== 1'b0 || ak_seq !== 12'h7FF) $display("FAIL nak_hold: got %b %h want 0 7ff", ak_valid, ak_seq); else n_pass++;
  endtask

  task automatic test_vc_unsup();
    do_clear();
    dllp[47:0] = mk_fc(8'hA3, 6'h11, 12'h222);
    dval = 2'b01;
    cyc(); idle(); cyc();
    n_checks++; if (fc_valid !== 3'b0) $display("FAIL vc_drop_valid: got %b want 000", fc_valid); else n_pass++;
    n_checks++; if (crc_cnt !== '0 || uns_cnt !== '0) $display("FAIL vc_drop_cnt: got %0d %0d want 0 0", crc_cnt, uns_cnt); else n_pass++;
    dllp = {mk_fc(8'h31, 6'h00, 12'h000), mk_fc(8'h80, 6'h3F, 12'hFFF)};
    dval = 2'b10;
    cyc(); idle(); cyc();
    n_checks++; if (uns_cnt !== 8'd1) $display("FAIL unsup_cnt: got %0d want 1", uns_cnt); else n_pass++;
    n_checks++; if (fc_valid !== 3'b0) $display("FAIL invalid_slot_ignored: got %b want 000", fc_valid); else n_pass++;
  endtask

  task automatic test_clear();
    do_clear();
    dllp[47:0] = corrupt(mk_fc(8'h80, 6'h02, 12'h003));
    dval = 2'b01;
    cyc();
    idle();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    n_checks++; if (crc_cnt !== '0) $display("FAIL clear_wins: got %0d want 0", crc_cnt); else n_pass++;
    dllp = {mk_fc(8'hD0, 6'h01, 12'h010), mk_fc(8'hC0, 6'h02, 12'h020)};
    dval = 2'b11;
    cyc();
    dllp = {48'h0, mk_fc(8'hE0, 6'h03, 12'h030)};
    dval = 2'b01;
    cyc(); idle(); cyc();
    n_checks++; if (seen2 !== 3'b111) $display("FAIL initfc2_seen: got %b want 111", seen2); else n_pass++;
    n_checks++; if (fc_phase[5:4] !== 2'b10) $display("FAIL initfc2_phase: got %b want 10", fc_phase[5:4]); else n_pass++;
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    n_checks++; if (seen2 !== 3'b000) $display("FAIL initfc2_clear: got %b want 000", seen2); else n_pass++;
  endtask

  task automatic test_back_to_back();
    idle();
    dllp[47:0] = mk_fc(8'h80, 6'h01, 12'h111);
    dval = 2'b01;
    cyc();
    dllp[47:0] = mk_fc(8'h80, 6'h02, 12'h222);
    cyc();
    idle();
    n_checks++; if (fc_valid !== 3'b001 || fc_hdr[5:0] !== 6'h01) $display("FAIL b2b_first: got %b %h want 001 01", fc_valid, fc_hdr[5:0]); else n_pass++;
    cyc();
    n_checks++; if (fc_valid !== 3'b001 || fc_hdr[5:0] !== 6'h02) $display("FAIL b2b_second: got %b %h want 001 02", fc_valid, fc_hdr[5:0]); else n_pass++;
    cyc();
    n_checks++; if (fc_valid !== 3'b000) $display("FAIL b2b_end: got %b want 000", fc_valid); else n_pass++;
  endtask

  task automatic test_reset_midflight();
    idle();
    dllp = {mk_fc(8'h40, 6'h05, 12'h050), corrupt(mk_fc(8'h90, 6'h06, 12'h060))};
    dval = 2'b11;
    cyc();
    idle();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_checks++; if ({fc_valid, fc_phase, fc_hdr, fc_data, ak_valid, ak_nak, ak_seq} !== '0) $display("FAIL midrst_outputs: got %h want 0", {fc_valid, fc_phase, fc_hdr, fc_data}); else n_pass++;
    cyc();
    n_checks++; if (fc_valid !== 3'b0 || seen1 !== 3'b0 || crc_cnt !== '0) $display("FAIL midrst_after: got %b %b %0d want 0 0 0", fc_valid, seen1, crc_cnt); else n_pass++;
  endtask

  task automatic test_random();
    grp_t g, cur;
    logic [7:0] t;
    int hi;
    idle();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) begin
        case ($urandom_range(0, 4))
          0: dllp[48*k +: 48] = corrupt(mk_fc(8'h80, 6'($urandom), 12'($urandom)));
          1, 2: begin
            t = {4'(4 + 4 * $urandom_range(0, 2) + $urandom_range(0, 2)), 1'b0, 3'($urandom_range(0, 1))};
            dllp[48*k +: 48] = mk_fc(t, 6'($urandom), 12'($urandom));
          end
          3: dllp[48*k +: 48] = mk_ak(1'($urandom), 12'($urandom));
          default: begin
            t = 8'($urandom);
            hi = int'(t) / 16;
            if ((hi >= 4 && hi <= 6) || (hi >= 8 && hi <= 10) || (hi >= 12 && hi <= 14)) t[3] = 1'b0;
            dllp[48*k +: 48] = mk_fc(t, 6'($urandom), 12'($urandom));
          end
        endcase
      end
      dval = N'($urandom);
      clr  = ($urandom_range(0, 15) == 0);
      cur.d = dllp;
      cur.v = dval;
      cyc();
      g = pipe_q.pop_front();
      model_apply(g, clr);
      pipe_q.push_back(cur);
      n_checks++; if (fc_valid !== m_fcv) $display("FAIL rnd_fc_valid c%0d: got %b want %b", c, fc_valid, m_fcv); else n_pass++;
      for (int f = 0; f < 3; f++) begin
        n_checks++;
        if (fc_phase[2*f +: 2] !== m_ph[f] || fc_hdr[6*f +: 6] !== m_hdr[f] || fc_data[12*f +: 12] !== m_dat[f])
          $display("FAIL rnd_fc_fields c%0d t%0d: got %b %h %h want %b %h %h", c, f,
                   fc_phase[2*f +: 2], fc_hdr[6*f +: 6], fc_data[12*f +: 12], m_ph[f], m_hdr[f], m_dat[f]);
        else n_pass++;
      end
      n_checks++; if ({ak_valid, ak_nak, ak_seq} !== {m_akv, m_nak, m_seq}) $display("FAIL rnd_acknak c%0d: got %b %b %h want %b %b %h", c, ak_valid, ak_nak, ak_seq, m_akv, m_nak, m_seq); else n_pass++;
      n_checks++; if (seen1 !== m_s1 || seen2 !== m_s2) $display("FAIL rnd_seen c%0d: got %b %b want %b %b", c, seen1, seen2, m_s1, m_s2); else n_pass++;
      n_checks++; if (int'(crc_cnt) != m_crc || int'(uns_cnt) != m_uns) $display("FAIL rnd_counters c%0d: got %0d %0d want %0d %0d", c, crc_cnt, uns_cnt, m_crc, m_uns); else n_pass++;
    end
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_single_updatefc();
    test_same_cycle_merge();
    test_crc_nak_saturate();
    test_vc_unsup();
    test_clear();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
